// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM state encoding and
// the conventional result-source indices.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_e;

    localparam int SRC_ALU     = 0;
    localparam int SRC_PCPLUS4 = 1;
    localparam int SRC_MEM     = 2;
    localparam int SRC_IO      = 3;

endpackage

// File: rtl/wb_src_mux.sv
// Combinational N-way result-source select; an out-of-range select yields zero.
module wb_src_mux #(
    parameter int DBITS = 32,
    parameter int NSRC  = 4
) (
    input  logic [$clog2(NSRC)-1:0] sel,
    input  logic [NSRC*DBITS-1:0]   src_data,
    output logic [DBITS-1:0]        out_data
);

    always_comb begin
        out_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (int'(sel) == k) begin
                out_data = src_data[k*DBITS +: DBITS];
            end
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects a result source (or waits for memory return data) and
// drives a registered register-file write. Define WB_FWD_EN to add forwarding outputs.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DBITS   = 32,
    parameter int REGBITS = 4,
    parameter int NSRC    = 4,
    parameter int MEM_SRC = SRC_MEM,
    parameter int TIMEOUT = 16,
    parameter int SELBITS = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELBITS-1:0]    in_sel,
    input  logic                  in_we,
    input  logic [REGBITS-1:0]    in_dst,
    input  logic [NSRC*DBITS-1:0] src_data,
    input  logic                  mem_rvalid,
    input  logic [DBITS-1:0]      mem_rdata,
    output logic                  wr_en,
    output logic [REGBITS-1:0]    wr_addr,
    output logic [DBITS-1:0]      wr_data,
    output logic                  err
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [REGBITS-1:0]    fwd_addr,
    output logic [DBITS-1:0]      fwd_data,
    output logic                  fwd_pending
`endif
);

    localparam int MUXSEL  = $clog2(NSRC);
    localparam int CNTBITS = $clog2(TIMEOUT + 1);

    wb_state_e          state;
    logic [CNTBITS-1:0] wait_cnt;
    logic [REGBITS-1:0] pend_dst;
    logic               pend_we;
    logic [DBITS-1:0]   mux_data;
    logic               accept;
    logic               sel_bad;
    logic               sel_mem;

    assign in_ready = (state != WAIT_MEM);
    assign accept   = in_valid && in_ready;
    assign sel_bad  = int'(in_sel) >= NSRC;
    assign sel_mem  = int'(in_sel) == MEM_SRC;

    wb_src_mux #(
        .DBITS(DBITS),
        .NSRC (NSRC)
    ) u_src_mux (
        .sel     (in_sel[MUXSEL-1:0]),
        .src_data(src_data),
        .out_data(mux_data)
    );

    // wr_addr/wr_data only move on an actual write so they hold between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
            pend_dst <= '0;
            pend_we  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                IDLE, WRITE: begin
                    if (!accept) begin
                        state <= IDLE;
                    end else if (sel_bad) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (sel_mem) begin
                        pend_dst <= in_dst;
                        pend_we  <= in_we;
                        wait_cnt <= '0;
                        state    <= WAIT_MEM;
                    end else begin
                        wr_en <= in_we;
                        if (in_we) begin
                            wr_addr <= in_dst;
                            wr_data <= mux_data;
                        end
                        state <= WRITE;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        wr_en <= pend_we;
                        if (pend_we) begin
                            wr_addr <= pend_dst;
                            wr_data <= mem_rdata;
                        end
                        state <= WRITE;
                    end else if (wait_cnt == CNTBITS'(TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNTBITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid   = wr_en;
    assign fwd_addr    = wr_addr;
    assign fwd_data    = wr_data;
    assign fwd_pending = (state == WAIT_MEM);
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writes and error pulses are queued
// with their due cycle when stimulus is driven and matched as the DUT produces them.
module tb_writeback_stage;

    localparam int DBITS   = 32;
    localparam int REGBITS = 4;
    localparam int NSRC    = 4;
    localparam int SELBITS = 3;
    localparam int TIMEOUT = 16;

    typedef struct {
        int                 cyc;
        logic [REGBITS-1:0] addr;
        logic [DBITS-1:0]   data;
    } wr_exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid;
    logic                  in_ready;
    logic [SELBITS-1:0]    in_sel;
    logic                  in_we;
    logic [REGBITS-1:0]    in_dst;
    logic [NSRC*DBITS-1:0] src_data;
    logic                  mem_rvalid;
    logic [DBITS-1:0]      mem_rdata;
    logic                  wr_en;
    logic [REGBITS-1:0]    wr_addr;
    logic [DBITS-1:0]      wr_data;
    logic                  err;
`ifdef WB_FWD_EN
    logic                  fwd_valid;
    logic [REGBITS-1:0]    fwd_addr;
    logic [DBITS-1:0]      fwd_data;
    logic                  fwd_pending;
`endif

    wr_exp_t wr_q[$];
    int      err_q[$];
    wr_exp_t e;
    int      n_checks = 0;
    int      n_fail = 0;
    int      cyc = 0;
    int      t0;

    writeback_stage #(
        .DBITS  (DBITS),
        .REGBITS(REGBITS),
        .NSRC   (NSRC),
        .MEM_SRC(2),
        .TIMEOUT(TIMEOUT),
        .SELBITS(SELBITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_we     (in_we),
        .in_dst    (in_dst),
        .src_data  (src_data),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err       (err)
`ifdef WB_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .fwd_pending(fwd_pending)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [SELBITS-1:0] sel, input logic [REGBITS-1:0] dst,
                         input logic we, input logic [DBITS-1:0] data);
        check_eq("in_ready_at_issue", in_ready, 1'b1);
        in_valid = 1'b1;
        in_sel   = sel;
        in_dst   = dst;
        in_we    = we;
        for (int k = 0; k < NSRC; k++) src_data[k*DBITS +: DBITS] = $urandom();
        if (int'(sel) < NSRC && int'(sel) != 2) begin
            src_data[int'(sel)*DBITS +: DBITS] = data;
            if (we) wr_q.push_back('{cyc + 1, dst, data});
        end else if (int'(sel) >= NSRC) begin
            err_q.push_back(cyc + 1);
        end
        step();
        in_valid = 1'b0;
    endtask

    // Output monitor: every strobe must match the oldest expectation on the right cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                check_eq("wr_unexpected", wr_en, 1'b0);
            end else begin
                e = wr_q.pop_front();
                check_eq("wr_cycle", cyc, e.cyc);
                check_eq("wr_addr", wr_addr, e.addr);
                check_eq("wr_data", wr_data, e.data);
`ifdef WB_FWD_EN
                check_eq("fwd_valid", fwd_valid, 1'b1);
                check_eq("fwd_addr", fwd_addr, e.addr);
                check_eq("fwd_data", fwd_data, e.data);
`endif
            end
        end
        if (err === 1'b1) begin
            if (err_q.size() == 0) check_eq("err_unexpected", err, 1'b0);
            else check_eq("err_cycle", cyc, err_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid   = 1'b0;
        in_sel     = '0;
        in_we      = 1'b0;
        in_dst     = '0;
        src_data   = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) step();
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        step();

        // Single ALU write, latency one
        issue(3'd0, 4'd5, 1'b1, 32'h0000_1234);
        step();

        // Back-to-back PC+4 writes
        issue(3'd1, 4'd1, 1'b1, 32'h1111_0001);
        issue(3'd1, 4'd2, 1'b1, 32'h2222_0002);
        issue(3'd1, 4'd3, 1'b1, 32'h3333_0003);

        // Non-writing request leaves the last write's address/data in place
        issue(3'd3, 4'd8, 1'b0, 32'h5555_5555);
        check_eq("hold_addr", wr_addr, 4'd3);
        check_eq("hold_data", wr_data, 32'h3333_0003);
        step();

        // Load: rvalid in the accept cycle is ignored; real data after 4 wait cycles
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        issue(3'd2, 4'd7, 1'b1, 32'h0);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("load_ready_low", in_ready, 1'b0);
`ifdef WB_FWD_EN
            check_eq("fwd_pending", fwd_pending, 1'b1);
`endif
            if (i == 3) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
                wr_q.push_back('{cyc + 1, 4'd7, 32'hDEAD_BEEF});
            end
            step();
        end
        // rvalid still high in WRITE must not produce a second write
        check_eq("load_ready_back", in_ready, 1'b1);
        step();
        mem_rvalid = 1'b0;
        check_eq("hold_after_load", wr_addr, 4'd7);

        // Timeout: no data ever arrives
        t0 = cyc;
        err_q.push_back(t0 + 1 + TIMEOUT);
        issue(3'd2, 4'd9, 1'b1, 32'h0);
        for (int i = 0; i < TIMEOUT; i++) begin
            check_eq("timeout_ready_low", in_ready, 1'b0);
            step();
        end
        check_eq("timeout_ready_back", in_ready, 1'b1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        step();
        mem_rvalid = 1'b0;
        check_eq("timeout_no_write", wr_addr, 4'd7);

        // Out-of-range select, then an immediate valid request
        issue(3'd5, 4'd6, 1'b1, 32'hFFFF_0000);
        issue(3'd0, 4'd10, 1'b1, 32'hA5A5_0001);
        step();

        // Reset in WAIT_MEM abandons the load
        issue(3'd2, 4'd4, 1'b1, 32'h0);
        step();
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_wr_en", wr_en, 1'b0);
        check_eq("midrst_wr_addr", wr_addr, 0);
        check_eq("midrst_wr_data", wr_data, 0);
        check_eq("midrst_in_ready", in_ready, 1'b1);
        step();
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        repeat (2) step();
        check_eq("postrst_wr_addr", wr_addr, 0);
        check_eq("postrst_wr_data", wr_data, 0);

        step();
        check_eq("wr_q_drained", wr_q.size(), 0);
        check_eq("err_q_drained", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
